// File: rtl/doctor_dispatch.sv
// -----------------------------------------------------------------------------
// doctor_dispatch
//
// Doctor-side consumer of the patient priority queue. When the doctor is free
// and the queue holds at least one patient, a one-cycle dequeue request is
// issued. The {priority, ID} word returned by the queue is captured, and the
// patient is held "in treatment" for a priority-dependent number of cycles.
// Completion is then signalled with a one-cycle pulse.
//
// Treatment duration = TREAT_BASE + TREAT_STEP * prio. It is computed in
// TIMER_W+2 bits, saturated to 2^TIMER_W-1, and forced to at least 1.
//
// Optional feature macro: DISPATCH_STATS_EN
//   defined     -> treated_cnt is a saturating count of completed treatments
//   not defined -> treated_cnt is tied to 0
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   doc_ready    in   doctor free to receive the next patient
//   q_count      in   current queue occupancy (CNT_W bits)
//   q_data       in   queue output word: [3:2] priority (11 = most urgent),
//                     [1:0] patient ID; valid the cycle after ende
//   ende         out  one-cycle dequeue request to the queue
//   busy         out  dispatcher engaged (REQ, CAPTURE, TREAT, DONE)
//   cur_prio     out  priority of the patient under treatment
//   cur_id       out  ID of the patient under treatment
//   done         out  one-cycle pulse when a treatment completes
//   treated_cnt  out  completed-treatment count (see macro above)
// -----------------------------------------------------------------------------
module doctor_dispatch #(
  parameter int TREAT_BASE = 2,
  parameter int TREAT_STEP = 2,
  parameter int TIMER_W    = 8,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             doc_ready,
  input  logic [CNT_W-1:0] q_count,
  input  logic [3:0]       q_data,
  output logic             ende,
  output logic             busy,
  output logic [1:0]       cur_prio,
  output logic [1:0]       cur_id,
  output logic             done,
  output logic [7:0]       treated_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    TREAT,
    DONE
  } state_t;

  // Two guard bits above the timer width so that the saturation check can see
  // an overflow of the base + step * prio sum.
  localparam int DUR_W = TIMER_W + 2;
  localparam logic [DUR_W-1:0] BASE_EXT = DUR_W'(TREAT_BASE);
  localparam logic [DUR_W-1:0] STEP_EXT = DUR_W'(TREAT_STEP);
  localparam logic [DUR_W-1:0] DUR_MAX  = {2'b00, {TIMER_W{1'b1}}};

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic [DUR_W-1:0]   dur_full;
  logic [TIMER_W-1:0] dur;
  logic               treat_last;

  // Duration for the word currently on q_data. It is only consumed in CAPTURE,
  // which is when the queue guarantees q_data is valid.
  // NOTE: every always_comb output is assigned on every path (dur_full first,
  // dur in each branch), so no latch can be inferred.
  always_comb begin
    dur_full = BASE_EXT + STEP_EXT * DUR_W'(q_data[3:2]);
    if (dur_full > DUR_MAX) begin
      dur = '1;
    end else if (dur_full == '0) begin
      dur = TIMER_W'(1);
    end else begin
      dur = dur_full[TIMER_W-1:0];
    end
  end

  // The timer is loaded with the duration and counts down to 1. The cycle in
  // which it reads 1 is therefore the last TREAT cycle.
  assign treat_last = (state == TREAT) && (timer == TIMER_W'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      ende     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_prio <= '0;
      cur_id   <= '0;
    end else begin
      // Pulse outputs default low; they are raised only on the transition
      // into the one state in which they are valid.
      ende <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (doc_ready && (q_count != '0)) begin
            state <= REQ;
            ende  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          cur_prio <= q_data[3:2];
          cur_id   <= q_data[1:0];
          timer    <= dur;
          state    <= TREAT;
        end
        TREAT: begin
          if (treat_last) begin
            state <= DONE;
            done  <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  // Counts on the same edge that raises done, so the count already includes
  // the current patient while done is high. The count holds at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      treated_cnt <= '0;
    end else if (treat_last && (treated_cnt != 8'hFF)) begin
      treated_cnt <= treated_cnt + 8'd1;
    end
  end
`else
  assign treated_cnt = '0;
`endif

endmodule
